// File: rtl/matmul_output_collector.sv
// Output collector for the systolic matmul array.
// Captures staggered, held column words from the array and the weight-proxy bus
// into two ROWS x COLS accumulators, merges them (wrap or saturate) and writes
// the merged matrix to memory one row per strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready; capture enabled; fsm_done starts a write-out
// S_WRITE | one-cycle row strobe (mem_wr_en high)
// S_WAIT  | remaining memory access cycles of the current row
module matmul_output_collector #(
  parameter int          ROWS               = 4,
  parameter int          COLS               = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          HOLD_CYCLES        = 2,
  parameter int          MEM_ACCESS_LATENCY = 2,
  parameter int          SATURATE           = 0,
  parameter logic [31:0] BASE_ADDR          = 32'd0,
  parameter logic [31:0] ADDR_INCR          = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      acc_mode,
  input  logic                      fsm_done,
  input  logic [COLS*WORD_SIZE-1:0] sa_out_bus,
  input  logic [COLS-1:0]           sa_valid,
  input  logic [COLS*WORD_SIZE-1:0] proxy_out_bus,
  input  logic [COLS-1:0]           proxy_valid,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [COLS*WORD_SIZE-1:0] mem_data,
  output logic                      overflow_err
);

  localparam int RW        = $clog2(ROWS + 1);
  localparam int PW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW        = (MEM_ACCESS_LATENCY > 2) ? $clog2(MEM_ACCESS_LATENCY - 1) : 1;
  localparam int WAIT_LOAD = (MEM_ACCESS_LATENCY > 1) ? MEM_ACCESS_LATENCY - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  // Signed add of two words, either wrapping or clamped to the signed range.
  function automatic logic [WORD_SIZE-1:0] add_w(input logic [WORD_SIZE-1:0] a,
                                                  input logic [WORD_SIZE-1:0] b);
    logic [WORD_SIZE:0] s;
    s = {a[WORD_SIZE-1], a} + {b[WORD_SIZE-1], b};
    if ((SATURATE != 0) && (s[WORD_SIZE] != s[WORD_SIZE-1]))
      add_w = s[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
    else
      add_w = s[WORD_SIZE-1:0];
  endfunction

  function automatic logic [PW-1:0] phase_nxt(input logic [PW-1:0] p);
    phase_nxt = (p == PW'(HOLD_CYCLES - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t                      state_q, state_d;
  logic [RW-1:0]               row_idx_q, row_idx_d;
  logic [WW-1:0]               wait_q, wait_d;

  logic [WORD_SIZE-1:0]        sa_acc_q [ROWS][COLS];
  logic [WORD_SIZE-1:0]        px_acc_q [ROWS][COLS];
  logic [PW-1:0]               sa_phase_q [COLS];
  logic [PW-1:0]               px_phase_q [COLS];
  logic [RW-1:0]               sa_row_q [COLS];
  logic [RW-1:0]               px_row_q [COLS];

  logic [COLS-1:0]             sa_take, px_take, sa_drop, px_drop;
  logic                        cap_en, complete, clear_acc;

  logic                        wr_en_q, wr_en_d;
  logic                        done_q, done_d;
  logic [31:0]                 addr_q, addr_d;
  logic [COLS*WORD_SIZE-1:0]   data_q, data_d;
  logic                        ovf_q;

  assign cap_en    = (state_q == S_IDLE) && !stall;
  assign complete  = (state_q != S_IDLE) && (state_d == S_IDLE);
  assign clear_acc = complete && !acc_mode;

  // A lane samples on the first cycle of each held word; samples past the last row are dropped.
  always_comb begin
    sa_take = '0;
    px_take = '0;
    sa_drop = '0;
    px_drop = '0;
    for (int c = 0; c < COLS; c++) begin
      sa_take[c] = cap_en && sa_valid[c] && (sa_phase_q[c] == '0);
      px_take[c] = cap_en && proxy_valid[c] && (px_phase_q[c] == '0);
      sa_drop[c] = sa_take[c] && (sa_row_q[c] == RW'(ROWS));
      px_drop[c] = px_take[c] && (px_row_q[c] == RW'(ROWS));
    end
  end

  // Per-lane hold phase and row counters; frozen outside IDLE, cleared when a write-out completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) begin
        sa_phase_q[c] <= '0;
        px_phase_q[c] <= '0;
        sa_row_q[c]   <= '0;
        px_row_q[c]   <= '0;
      end
    end else if (complete) begin
      for (int c = 0; c < COLS; c++) begin
        sa_phase_q[c] <= '0;
        px_phase_q[c] <= '0;
        sa_row_q[c]   <= '0;
        px_row_q[c]   <= '0;
      end
    end else if (cap_en) begin
      for (int c = 0; c < COLS; c++) begin
        sa_phase_q[c] <= sa_valid[c] ? phase_nxt(sa_phase_q[c]) : '0;
        px_phase_q[c] <= proxy_valid[c] ? phase_nxt(px_phase_q[c]) : '0;
        if (sa_take[c] && !sa_drop[c]) sa_row_q[c] <= sa_row_q[c] + 1'b1;
        if (px_take[c] && !px_drop[c]) px_row_q[c] <= px_row_q[c] + 1'b1;
      end
    end
  end

  // Accumulate captured words into the element addressed by the lane's row counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          sa_acc_q[r][c] <= '0;
          px_acc_q[r][c] <= '0;
        end
    end else if (clear_acc) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          sa_acc_q[r][c] <= '0;
          px_acc_q[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          if (sa_take[c] && !sa_drop[c] && (sa_row_q[c] == RW'(r)))
            sa_acc_q[r][c] <= add_w(sa_acc_q[r][c], sa_out_bus[c*WORD_SIZE +: WORD_SIZE]);
          if (px_take[c] && !px_drop[c] && (px_row_q[c] == RW'(r)))
            px_acc_q[r][c] <= add_w(px_acc_q[r][c], proxy_out_bus[c*WORD_SIZE +: WORD_SIZE]);
        end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       ovf_q <= 1'b0;
    else if (|{sa_drop, px_drop})   ovf_q <= 1'b1;
  end

  // FSM state register with row index and access-wait down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_idx_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      wait_q    <= wait_d;
    end
  end

  // FSM next state; row_idx counts rows already strobed.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        row_idx_d = '0;
        if (fsm_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        row_idx_d = row_idx_q + 1'b1;
        if (MEM_ACCESS_LATENCY > 1) begin
          state_d = S_WAIT;
          wait_d  = WW'(WAIT_LOAD);
        end else if (row_idx_q == RW'(ROWS - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = (row_idx_q == RW'(ROWS)) ? S_IDLE : S_WRITE;
        else              wait_d  = wait_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobe, address and merged row are prepared for the upcoming WRITE cycle.
  always_comb begin
    wr_en_d = (state_d == S_WRITE);
    done_d  = complete;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_d == S_WRITE) begin
      addr_d = BASE_ADDR + 32'(row_idx_d) * ADDR_INCR;
      for (int r = 0; r < ROWS; r++)
        if (row_idx_d == RW'(r))
          for (int c = 0; c < COLS; c++)
            data_d[c*WORD_SIZE +: WORD_SIZE] = add_w(sa_acc_q[r][c], px_acc_q[r][c]);
    end
  end

  // Registered memory interface; address and data hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_output_rdy  = (state_q == S_IDLE);
  assign wr_output_done = done_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_addr       = addr_q;
  assign mem_data       = data_q;
  assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_matmul_output_collector.sv
// Bench for matmul_output_collector: a wrapping and a saturating instance share
// all inputs; table of merge/accumulate vectors plus hand-written corner sequences.
module tb_matmul_output_collector;
  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst, stall, acc_mode, fsm_done;
  logic [C*W-1:0] sa_bus, px_bus;
  logic [C-1:0]   sa_v, px_v;

  logic           rdy_w, done_w, we_w, ovf_w;
  logic [31:0]    addr_w;
  logic [C*W-1:0] data_w;
  logic           rdy_s, done_s, we_s, ovf_s;
  logic [31:0]    addr_s;
  logic [C*W-1:0] data_s;

  int tests  = 0;
  int errors = 0;

  logic [W-1:0]   tb_sa [R][C];
  logic [W-1:0]   tb_px [R][C];
  logic [C*W-1:0] exp_w [R];
  logic [C*W-1:0] exp_s [R];

  typedef struct {
    logic [W-1:0] sa0, sao, px0;
    bit           am;
    logic [W-1:0] ew0, ewo, es0, eso;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  matmul_output_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .HOLD_CYCLES(2),
    .MEM_ACCESS_LATENCY(2), .SATURATE(0), .BASE_ADDR(32'd0), .ADDR_INCR(32'd4)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .acc_mode(acc_mode), .fsm_done(fsm_done),
    .sa_out_bus(sa_bus), .sa_valid(sa_v), .proxy_out_bus(px_bus), .proxy_valid(px_v),
    .wr_output_rdy(rdy_w), .wr_output_done(done_w), .mem_addr(addr_w),
    .mem_wr_en(we_w), .mem_data(data_w), .overflow_err(ovf_w));

  matmul_output_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .HOLD_CYCLES(2),
    .MEM_ACCESS_LATENCY(2), .SATURATE(1), .BASE_ADDR(32'd0), .ADDR_INCR(32'd4)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .acc_mode(acc_mode), .fsm_done(fsm_done),
    .sa_out_bus(sa_bus), .sa_valid(sa_v), .proxy_out_bus(px_bus), .proxy_valid(px_v),
    .wr_output_rdy(rdy_s), .wr_output_done(done_s), .mem_addr(addr_s),
    .mem_wr_en(we_s), .mem_data(data_s), .overflow_err(ovf_s));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [C*W-1:0] row_of(input logic [W-1:0] l0, input logic [W-1:0] lo);
    row_of = {lo, lo, lo, l0};
  endfunction

  // Lane c is valid for 8 cycles starting at cycle c; word k/2 of the lane is held 2 cycles.
  // During a stall window the bus contents are frozen.
  task automatic stream(input int stall_at, input bit px_en);
    int t, cyc, k;
    t = 0;
    cyc = 0;
    while (t < 12) begin
      stall = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      for (int c = 0; c < C; c++) begin
        k = t - c;
        if (k >= 0 && k < 8) begin
          sa_v[c]          = 1'b1;
          sa_bus[c*W +: W] = tb_sa[k/2][c];
          px_v[c]          = px_en;
          px_bus[c*W +: W] = px_en ? tb_px[k/2][c] : '0;
        end else begin
          sa_v[c]          = 1'b0;
          sa_bus[c*W +: W] = '0;
          px_v[c]          = 1'b0;
          px_bus[c*W +: W] = '0;
        end
      end
      @(posedge clk); #1;
      if (!stall) t++;
      cyc++;
    end
    sa_v = '0; px_v = '0; sa_bus = '0; px_bus = '0; stall = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pulse fsm_done and follow the write-out: strobes at +1,+3,+5,+7, done at +9.
  task automatic do_write(input bit am);
    int rows;
    bit got;
    rows = 0;
    got = 0;
    acc_mode = am;
    fsm_done = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      fsm_done = 1'b0;
      if (k == 1) check("rdy_low_in_write", rdy_w, 0);
      if (we_w) begin
        check("strobe_cycle", k, 1 + 2*rows);
        if (rows < R) begin
          check("addr_w", addr_w, rows*4);
          check("addr_s", addr_s, rows*4);
          check("data_w", data_w, exp_w[rows]);
          check("data_s", data_s, exp_s[rows]);
          check("we_s", we_s, 1);
        end
        rows++;
      end
      if (done_w) begin
        got = 1;
        check("done_cycle", k, 9);
        check("row_count", rows, R);
        check("done_s", done_s, 1);
        check("rdy_after_done", rdy_w, 1);
      end
    end
    if (!got) begin
      tests++;
      errors++;
      $display("FAIL done_timeout: no wr_output_done within 20 cycles, rows seen %0d", rows);
    end
    @(posedge clk); #1;
    check("done_one_cycle", done_w, 0);
    acc_mode = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int strobes;
    //          sa0       sao       px0       am  ew0       ewo       es0       eso
    vecs[0] = '{16'h000A, 16'h0021, 16'hFFFD, 0, 16'h0007, 16'h0021, 16'h0007, 16'h0021};
    vecs[1] = '{16'h7FF0, 16'h0001, 16'h0020, 0, 16'h8010, 16'h0001, 16'h7FFF, 16'h0001};
    vecs[2] = '{16'h0005, 16'h0005, 16'h0000, 1, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    vecs[3] = '{16'h0005, 16'h0005, 16'h0000, 0, 16'h000A, 16'h000A, 16'h000A, 16'h000A};
    vecs[4] = '{16'h0005, 16'h0005, 16'h0000, 0, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    vecs[5] = '{16'h8000, 16'hFF9C, 16'hFFFF, 0, 16'h7FFF, 16'hFF9C, 16'h8000, 16'hFF9C};
    vecs[6] = '{16'h6000, 16'h6000, 16'h0000, 1, 16'h6000, 16'h6000, 16'h6000, 16'h6000};
    vecs[7] = '{16'h6000, 16'h6000, 16'h0000, 0, 16'hC000, 16'hC000, 16'h7FFF, 16'h7FFF};

    rst = 1'b0; stall = 1'b0; acc_mode = 1'b0; fsm_done = 1'b0;
    sa_bus = '0; px_bus = '0; sa_v = '0; px_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_w", rdy_w, 1);
    check("rst_rdy_s", rdy_s, 1);
    check("rst_done", done_w, 0);
    check("rst_we", we_w, 0);
    check("rst_addr", addr_w, 0);
    check("rst_data", data_w, 0);
    check("rst_ovf", ovf_w, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic staggered capture: row r = r+1 on every lane, proxy idle.
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin tb_sa[r][c] = W'(r + 1); tb_px[r][c] = '0; end
      exp_w[r] = row_of(W'(r + 1), W'(r + 1));
      exp_s[r] = exp_w[r];
    end
    stream(-1, 0);
    do_write(0);

    // Table vectors: merge, saturation, multi-tile accumulation.
    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          tb_sa[r][c] = (c == 0) ? vecs[v].sa0 : vecs[v].sao;
          tb_px[r][c] = (c == 0) ? vecs[v].px0 : '0;
        end
        exp_w[r] = row_of(vecs[v].ew0, vecs[v].ewo);
        exp_s[r] = row_of(vecs[v].es0, vecs[v].eso);
      end
      stream(-1, 1);
      do_write(vecs[v].am);
    end

    // Stall for 3 cycles mid-hold: results must match the unstalled capture.
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin tb_sa[r][c] = W'((r + 1)*16 + c); tb_px[r][c] = '0; end
      exp_w[r] = {W'((r + 1)*16 + 3), W'((r + 1)*16 + 2), W'((r + 1)*16 + 1), W'((r + 1)*16)};
      exp_s[r] = exp_w[r];
    end
    stream(5, 0);
    do_write(0);

    // Fifth word on lane 0 is dropped and flags overflow.
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) tb_sa[r][c] = 16'd2;
      exp_w[r] = row_of(16'd2, 16'd2);
      exp_s[r] = exp_w[r];
    end
    stream(-1, 0);
    check("ovf_before_extra", ovf_w, 0);
    sa_v[0] = 1'b1;
    sa_bus[0 +: W] = 16'd99;
    repeat (2) @(posedge clk);
    #1;
    sa_v = '0; sa_bus = '0;
    @(posedge clk); #1;
    check("ovf_w_set", ovf_w, 1);
    check("ovf_s_set", ovf_s, 1);
    do_write(0);
    check("ovf_sticky", ovf_w, 1);

    // Reset in WAIT after row 1: write aborts, accumulators cleared.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) tb_sa[r][c] = 16'd3;
    stream(-1, 0);
    fsm_done = 1'b1;
    @(posedge clk); #1;
    fsm_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_addr_row1", addr_w, 4);
    rst = 1'b0;
    #1;
    check("rst_mid_we", we_w, 0);
    check("rst_mid_rdy", rdy_w, 1);
    check("rst_mid_addr", addr_w, 0);
    check("rst_mid_ovf", ovf_w, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (we_w || we_s) strobes++;
    end
    check("no_strobe_after_rst", strobes, 0);
    for (int r = 0; r < R; r++) begin exp_w[r] = '0; exp_s[r] = '0; end
    do_write(0);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) tb_sa[r][c] = W'(r + 1);
      exp_w[r] = row_of(W'(r + 1), W'(r + 1));
      exp_s[r] = exp_w[r];
    end
    stream(-1, 0);
    do_write(0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/matmul_output_collector.md
Name: matmul_output_collector

Overview:
- Parametrised successor output path for weight/input-stationary matmul flows.
- Captures staggered, double-held column outputs from the systolic array and the weight-proxy bus into separate ROWS x COLS accumulators.
- Merges them with selectable wrap or saturating arithmetic, then streams the merged matrix to memory row by row.
- Adds multi-tile K accumulation, configurable hold length, overflow detection, and an explicit write handshake.

Parameters:
- ROWS, 4, output matrix rows (any value >= 1).
- COLS, 4, output matrix columns / bus lanes (any value >= 1).
- WORD_SIZE, 16, signed element width.
- HOLD_CYCLES, 2, cycles each valid output word is held on the bus (>= 1).
- MEM_ACCESS_LATENCY, 2, cycles per row write, counted from the mem_wr_en cycle (>= 1).
- SATURATE, 0, 1 = merged and accumulated sums saturate to the signed WORD_SIZE range; 0 = two's-complement wrap.
- BASE_ADDR, 0, memory address of row 0.
- ADDR_INCR, 4, address step per row.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- stall  input  1  freezes capture (hold counters and accumulators); does not freeze the write FSM.
- acc_mode  input  1  sampled at write completion: 0 = clear accumulators after write, 1 = keep them for the next K tile.
- fsm_done  input  1  single-cycle pulse: tile compute finished.
- sa_out_bus  input  COLS*WORD_SIZE  array outputs; lane c = bits [c*WORD_SIZE +: WORD_SIZE].
- sa_valid  input  COLS  per-lane valid.
- proxy_out_bus  input  COLS*WORD_SIZE  proxy outputs, same lane packing.
- proxy_valid  input  COLS  per-lane proxy valid.
- wr_output_rdy  output  1  high in IDLE.
- wr_output_done  output  1  one-cycle pulse after the last row write.
- mem_addr  output  32  row write address.
- mem_wr_en  output  1  one-cycle write strobe per row.
- mem_data  output  COLS*WORD_SIZE  merged row; lane packing matches the input buses.
- overflow_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - all accumulators, per-lane phase counters and row counters;
  - state to IDLE;
  - outputs: wr_output_rdy=1, wr_output_done=0, mem_wr_en=0, mem_addr=0, mem_data=0, overflow_err=0.
  - Reset mid-write aborts the write; no further strobes are issued.
- Capture (SA and proxy paths identical and independent):
  - Each lane has a phase counter, 0..HOLD_CYCLES-1.
  - When valid[c]=1 and stall=0: if phase==0, the lane samples, then phase advances modulo HOLD_CYCLES.
  - When valid[c]=0, phase resets to 0.
  - When stall=1, phase holds and nothing is sampled.
  - On a sample: acc[row_cnt[c]][c] += lane word, and row_cnt[c] increments.
  - A sample while row_cnt[c]==ROWS is dropped and sets overflow_err.
  - With SATURATE=1, accumulation saturates to the signed WORD_SIZE range; with SATURATE=0 it wraps.
  - Capture is enabled only in IDLE. Valid inputs in WRITE or WAIT are ignored and do not change phase.
- Merge: merged[r][c] = sa_acc[r][c] + proxy_acc[r][c], computed with the same SATURATE rule and sampled into mem_data at the strobe cycle.
- Write FSM:
  - IDLE: wr_output_rdy=1. fsm_done=1 moves to WRITE with row_idx=0. A fsm_done pulse outside IDLE is ignored.
  - WRITE: wr_output_rdy=0. Drives mem_wr_en=1 for one cycle with:
    - mem_addr = BASE_ADDR + row_idx*ADDR_INCR;
    - mem_data = merged row row_idx.
    - Then row_idx++. Go to WAIT if MEM_ACCESS_LATENCY>1; otherwise stay in WRITE for the next row.
  - WAIT: mem_wr_en=0 for MEM_ACCESS_LATENCY-1 cycles, then return to WRITE.
  - After row ROWS-1 completes: pulse wr_output_done for one cycle, clear all row and phase counters, and clear the accumulators if acc_mode=0. Return to IDLE.
- Timing: first strobe is 1 cycle after fsm_done; the done pulse is ROWS*MEM_ACCESS_LATENCY+1 cycles after fsm_done.
- mem_addr and mem_data hold their last values between strobes.
- overflow_err clears only on reset.

Test Plan:
- ROWS=COLS=4, HOLD=2: lane c valid for 8 cycles starting at cycle c, carrying values 1,2,3,4 (each held 2 cycles); proxy idle; fsm_done pulse -> 4 strobes at addresses 0,4,8,12; row r of mem_data has every lane = r+1; wr_output_done rises 9 cycles after fsm_done.
- Proxy merge: SA lane 0 rows = 10, proxy lane 0 rows = -3 -> written lane 0 = 7 for every row; other lanes equal their SA values.
- SATURATE=1: SA=0x7FF0, proxy=0x0020 -> written value 0x7FFF. With SATURATE=0 the same inputs give 0x8010.
- acc_mode=1 across two tiles each writing 5 into every element -> second write gives 10 everywhere. With acc_mode=0 the second write gives 5.
- Stall asserted for 3 cycles mid-hold -> no duplicate or missed samples; totals equal the unstalled result. Adding a 5th valid word on a lane -> sample dropped and overflow_err=1.
- rst low during WAIT after row 1 -> mem_wr_en=0 immediately; wr_output_rdy=1 and accumulators zero on release; the next tile writes correct values.
